alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised, handshaked multi-cycle ALU. It is the registered, flow-controlled successor to the team's combinational 8-bit ALU and keeps the same 4-bit opcode map. Single-cycle operations complete with a latency of 1. DIV uses an iterative restoring divider that produces both quotient and remainder. The block sits between an operand-issue stage and a result consumer, with valid/ready on both sides.

## Interface
- `W`, default 8: operand width. Results are 2W bits wide. W ≥ 2.
- `clk`, input, 1: single clock; everything is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: the operand triple is valid.
- `in_ready`, output, 1: the block accepts an operation this cycle.
- `in_a`, input, W: operand A, unsigned.
- `in_b`, input, W: operand B, unsigned.
- `in_sel`, input, 4: opcode.
- `out_valid`, output, 1: the result is valid.
- `out_ready`, input, 1: the consumer accepts the result.
- `out_result`, output, 2W: the result.
- `out_err`, output, 1: the result is an error (illegal opcode, or divide by zero).

## Operation
- Opcodes:
  - 0 ADD: zero-extended a+b.
  - 1 SUB: a−b as a 2W-bit two's-complement value.
  - 2 MUL: a*b.
  - 3 DIV: {remainder, quotient}, each W bits.
  - 4 AND: zero-extended a&b.
  - 5 OR: zero-extended a|b.
  - 6 NOT: {0, ~a}.
  - 7 XOR: zero-extended a^b.
  - 8 SL: 2W-bit a<<b. Gives 0 when b ≥ 2W.
  - 9 SR: a>>b.
  - 10–15: illegal. out_result=0, out_err=1.
- Transfer rules:
  - Accept on in_valid && in_ready.
  - Retire on out_valid && out_ready.
- FSM states:
  - IDLE: empty.
  - BUSY: divider iterating, with an iteration counter 0..W−1.
  - HOLD: result is valid.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). This gives back-to-back throughput of 1 op/cycle for non-DIV ops.
- IDLE/HOLD transitions on accept:
  - Non-DIV op: compute, register, go to HOLD.
  - DIV with b≠0: load the divider and go to BUSY.
  - DIV with b=0: register {a, all-ones} with err=1 and go to HOLD. This takes one cycle and skips BUSY.
- HOLD with retire and no new accept: go to IDLE.
- BUSY: produce one quotient bit per cycle. After the W-th iteration, go to HOLD. in_ready=0 throughout BUSY.
- Operands and opcode are captured at accept. Input changes after accept have no effect.
- HOLD outputs stay stable until retire, regardless of input activity.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, out_valid=0, out_result=0, out_err=0.
  - in_ready=1 from the first cycle after reset.
- Non-DIV, accepted at edge T: out_valid=1 after edge T.
- DIV (b≠0), accepted at edge T:
  - Iterations run at edges T+1..T+W.
  - out_valid=1 after edge T+W, so latency is W cycles.
  - in_ready=0 after T until HOLD.
- Retire and accept in the same HOLD cycle: the new result replaces the old one at the same edge, and out_valid stays 1.
- Retire plus accept of a DIV in HOLD: go to BUSY, and out_valid=0 on the next cycle.
- rst_n low mid-division: abort immediately, discard partial state, apply reset values.
- No combinational path from in_* to out_*.
- in_ready depends combinationally on out_ready only.

## Configuration
- `ALU_MC_DIV_EN` defined: iterative divider and BUSY state are present, with behaviour as above.
- `ALU_MC_DIV_EN` undefined:
  - No divider logic and no BUSY state.
  - Opcode 3 is treated as illegal: out_result=0, out_err=1, latency 1.

## Test plan
- W=8, ADD a=200 b=100 → out_result=0x012C, err=0, one cycle after accept. SUB a=5 b=10 → 0xFFFB.
- MUL a=255 b=255 → 0xFE01.
- Back-to-back XOR 0xF0^0x3C and NOT a=0x0F with out_ready=1 → 0x00CC, then 0x00F0, on consecutive cycles.
- DIV a=200 b=7:
  - in_ready=0 for 8 cycles.
  - out_result=0x041C, err=0.
  - DIV b=0 with a=0x55 → 0x55FF, err=1, one cycle.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD → out_result, out_err and out_valid stay stable, and in_ready=0. Raising out_ready retires the result and accepts the pending input in the same cycle.
- Reset and error cases:
  - rst_n low at iteration 4 of a DIV → outputs go to 0 immediately. After release, in_ready=1 and the next ADD 1+1 returns 0x0002.
  - in_sel=4'hA → result=0, err=1.
  - Without ALU_MC_DIV_EN: DIV 200/7 → 0, err=1.

Source files
------------

// File: rtl/alu_mc_if.sv
// Operand-issue / result-consume handshake bundle for alu_mc.
// The master drives operands and out_ready; the slave (the ALU) drives in_ready and results.
interface alu_mc_if #(
    parameter int W = 8
) ();
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic [3:0]     in_sel;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_result;
    logic           out_err;

    modport master (
        output in_valid, in_a, in_b, in_sel, out_ready,
        input  in_ready, out_valid, out_result, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, out_ready,
        output in_ready, out_valid, out_result, out_err
    );
endinterface

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: single-cycle ops with latency 1, iterative restoring divider.
// Define ALU_MC_DIV_EN to build the divider and BUSY state; otherwise opcode 3 is illegal.
module alu_mc #(
    parameter int W = 8
) (
    input logic     clk,
    input logic     rst_n,
    alu_mc_if.slave bus
);
    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
        OP_AND = 4'd4, OP_OR  = 4'd5, OP_NOT = 4'd6, OP_XOR = 4'd7,
        OP_SL  = 4'd8, OP_SR  = 4'd9
    } op_t;

`ifdef ALU_MC_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_HOLD} state_t;
`endif

    state_t         state_q, state_d;
    logic [2*W-1:0] res_q, res_d;
    logic           err_q, err_d;
    logic [2*W-1:0] op_res;
    logic           op_err;
    logic [2*W-1:0] wa, wb;
    logic           accept;

    assign bus.in_ready   = (state_q == S_IDLE) || (state_q == S_HOLD && bus.out_ready);
    assign accept         = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = (state_q == S_HOLD);
    assign bus.out_result = res_q;
    assign bus.out_err    = err_q;

    assign wa = {{W{1'b0}}, bus.in_a};
    assign wb = {{W{1'b0}}, bus.in_b};

    // Single-cycle result table; shifting by >= 2W naturally yields zero.
    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        op_res = '0;
        op_err = 1'b0;
        case (op_t'(bus.in_sel))
            OP_ADD: op_res = wa + wb;
            OP_SUB: op_res = wa - wb;
            OP_MUL: op_res = wa * wb;
            OP_AND: op_res = wa & wb;
            OP_OR:  op_res = wa | wb;
            OP_NOT: op_res = {{W{1'b0}}, ~bus.in_a};
            OP_XOR: op_res = wa ^ wb;
            OP_SL:  op_res = wa << bus.in_b;
            OP_SR:  op_res = wa >> bus.in_b;
`ifdef ALU_MC_DIV_EN
            OP_DIV: begin
                // Only reaches the result register for b == 0.
                op_res = {bus.in_a, {W{1'b1}}};
                op_err = 1'b1;
            end
`endif
            default: op_err = 1'b1;
        endcase
    end

`ifdef ALU_MC_DIV_EN
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    logic [W-1:0]  rem_q, quo_q, dvs_q;
    logic [W-1:0]  rem_n, quo_n;
    logic [CW-1:0] cnt_q;
    logic [W:0]    partial, diff;
    logic          start_div;
    logic          ge;

    assign start_div = accept && (op_t'(bus.in_sel) == OP_DIV) && (bus.in_b != '0);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The remainder stays below the divisor, so the borrow bit of diff decides.
    assign partial = {rem_q, quo_q[W-1]};
    assign diff    = partial - {1'b0, dvs_q};
    assign ge      = ~diff[W];
    assign rem_n   = ge ? diff[W-1:0] : partial[W-1:0];
    assign quo_n   = {quo_q[W-2:0], ge};

    // Reset clears partial results so an aborted division leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start_div) begin
            rem_q <= '0;
            quo_q <= bus.in_a;
            dvs_q <= bus.in_b;
            cnt_q <= '0;
        end else if (state_q == S_BUSY) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + CW'(1);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_HOLD: begin
                if (accept) begin
`ifdef ALU_MC_DIV_EN
                    if (start_div) state_d = S_BUSY;
                    else
`endif
                    begin
                        state_d = S_HOLD;
                        res_d   = op_res;
                        err_d   = op_err;
                    end
                end else if (state_q == S_HOLD && bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
`ifdef ALU_MC_DIV_EN
            S_BUSY: begin
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_HOLD;
                    res_d   = {rem_n, quo_n};
                    err_d   = 1'b0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed, table-driven bench for alu_mc (W=8) with hand sequences for division,
// backpressure and reset; expectations follow the ALU_MC_DIV_EN setting.
module tb_alu_mc;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec  = 0;
    int   n_fail = 0;

    alu_mc_if #(.W(W)) bus ();

    alu_mc #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sel;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                                input logic [15:0] r, input logic e);
        vec_t v;
        v.sel = s; v.a = a; v.b = b; v.res = r; v.err = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs.push_back(mk(4'd0, 8'd200, 8'd100, 16'h012C, 1'b0));
        vecs.push_back(mk(4'd1, 8'd5,   8'd10,  16'hFFFB, 1'b0));
        vecs.push_back(mk(4'd2, 8'd255, 8'd255, 16'hFE01, 1'b0));
        vecs.push_back(mk(4'd7, 8'hF0,  8'h3C,  16'h00CC, 1'b0));
        vecs.push_back(mk(4'd6, 8'h0F,  8'h00,  16'h00F0, 1'b0));
        vecs.push_back(mk(4'd4, 8'hF0,  8'h3C,  16'h0030, 1'b0));
        vecs.push_back(mk(4'd5, 8'hF0,  8'h3C,  16'h00FC, 1'b0));
        vecs.push_back(mk(4'd8, 8'h81,  8'd4,   16'h0810, 1'b0));
        vecs.push_back(mk(4'd8, 8'h01,  8'd15,  16'h8000, 1'b0));
        vecs.push_back(mk(4'd8, 8'h01,  8'd16,  16'h0000, 1'b0));
        vecs.push_back(mk(4'd9, 8'hF0,  8'd4,   16'h000F, 1'b0));
        vecs.push_back(mk(4'hA, 8'd3,   8'd4,   16'h0000, 1'b1));
        vecs.push_back(mk(4'hF, 8'hFF,  8'hFF,  16'h0000, 1'b1));
        vecs.push_back(mk(4'd0, 8'd255, 8'd255, 16'h01FE, 1'b0));
`ifdef ALU_MC_DIV_EN
        vecs.push_back(mk(4'd3, 8'h55,  8'd0,   16'h55FF, 1'b1));
`else
        vecs.push_back(mk(4'd3, 8'd200, 8'd7,   16'h0000, 1'b1));
        vecs.push_back(mk(4'd3, 8'h55,  8'd0,   16'h0000, 1'b1));
`endif

        rst_n = 1'b0;
        drive(1'b0, 4'd0, 8'd0, 8'd0);
        bus.out_ready = 1'b1;
        #12;
        check("rst_out_valid", 16'(bus.out_valid), 16'd0);
        check("rst_out_result", bus.out_result, 16'h0000);
        check("rst_out_err", 16'(bus.out_err), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 16'(bus.in_ready), 16'd1);

        // Back-to-back vectors: each edge retires the previous result and accepts the next op.
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].sel, vecs[i].a, vecs[i].b);
            step();
            check($sformatf("vec%0d_valid", i), 16'(bus.out_valid), 16'd1);
            check($sformatf("vec%0d_result", i), bus.out_result, vecs[i].res);
            check($sformatf("vec%0d_err", i), 16'(bus.out_err), 16'(vecs[i].err));
        end
        bus.in_valid = 1'b0;
        step();
        check("table_drain_valid", 16'(bus.out_valid), 16'd0);

`ifdef ALU_MC_DIV_EN
        // DIV 200/7: busy for W cycles, inputs changed during BUSY must not matter.
        drive(1'b1, 4'd3, 8'd200, 8'd7);
        step();
        drive(1'b0, 4'd3, 8'hFF, 8'h01);
        for (int i = 0; i < W; i++) begin
            check($sformatf("div_busy%0d_in_ready", i), 16'(bus.in_ready), 16'd0);
            check($sformatf("div_busy%0d_valid", i), 16'(bus.out_valid), 16'd0);
            step();
        end
        check("div_valid", 16'(bus.out_valid), 16'd1);
        check("div_result", bus.out_result, 16'h041C);
        check("div_err", 16'(bus.out_err), 16'd0);

        // Retire plus accept of another DIV in HOLD drops out_valid on the next cycle.
        drive(1'b1, 4'd3, 8'd100, 8'd9);
        step();
        bus.in_valid = 1'b0;
        check("div2_valid_drop", 16'(bus.out_valid), 16'd0);
        check("div2_in_ready", 16'(bus.in_ready), 16'd0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        check("div2_latency", 16'(n), 16'(W));
        check("div2_result", bus.out_result, 16'h010B);
        check("div2_err", 16'(bus.out_err), 16'd0);
        step();
        check("div2_retire", 16'(bus.out_valid), 16'd0);
`endif

        // Backpressure: result held stable while a MUL waits at the input.
        bus.out_ready = 1'b0;
        drive(1'b1, 4'd0, 8'd1, 8'd2);
        step();
        drive(1'b1, 4'd2, 8'd3, 8'd4);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_valid", i), 16'(bus.out_valid), 16'd1);
            check($sformatf("bp%0d_result", i), bus.out_result, 16'h0003);
            check($sformatf("bp%0d_err", i), 16'(bus.out_err), 16'd0);
            check($sformatf("bp%0d_in_ready", i), 16'(bus.in_ready), 16'd0);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 16'(bus.in_ready), 16'd1);
        step();
        bus.in_valid = 1'b0;
        check("bp_swap_valid", 16'(bus.out_valid), 16'd1);
        check("bp_swap_result", bus.out_result, 16'h000C);
        step();
        check("bp_drain_valid", 16'(bus.out_valid), 16'd0);

        // Asynchronous reset in the middle of an operation.
`ifdef ALU_MC_DIV_EN
        drive(1'b1, 4'd3, 8'd200, 8'd7);
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        check("mid_div_busy", 16'(bus.in_ready), 16'd0);
`else
        bus.out_ready = 1'b0;
        drive(1'b1, 4'd0, 8'd7, 8'd8);
        step();
        bus.in_valid = 1'b0;
        check("pre_rst_result", bus.out_result, 16'h000F);
`endif
        rst_n = 1'b0;
        #1;
        check("abort_valid", 16'(bus.out_valid), 16'd0);
        check("abort_result", bus.out_result, 16'h0000);
        check("abort_err", 16'(bus.out_err), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        check("abort_in_ready", 16'(bus.in_ready), 16'd1);
        drive(1'b1, 4'd0, 8'd1, 8'd1);
        step();
        bus.in_valid = 1'b0;
        check("abort_add_valid", 16'(bus.out_valid), 16'd1);
        check("abort_add_result", bus.out_result, 16'h0002);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
